dbg_uart_host: RTL and testbench

DBG_UART_HOST -- requirements
Module: dbg_uart_host

---
 rtl/uart_pkg.sv | 28 ++
 rtl/dbg_host_rx_unescape.sv | 52 +++++
 rtl/dbg_uart_host.sv | 202 ++++++++++++++++++++
 tb/tb_dbg_uart_host.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART debug host: escape byte, command codes,
// address width and the host FSM state type.
package uart_pkg;

  localparam int unsigned IRLENGTH      = 7;
  localparam int unsigned CMD_ADDR_BITS = 5;

  localparam logic [7:0] ESC_DEFAULT = 8'hB1;
  localparam logic [2:0] CMD_READ    = 3'b001;
  localparam logic [2:0] CMD_WRITE   = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    SEND_ESC,
    SEND_CMD,
    SEND_DATA,
    SEND_DUP,
    RECV,
    RECV_ESC,
    RESP
  } host_state_e;

  function automatic logic [7:0] cmd_byte(input logic [2:0] cmd,
                                          input logic [CMD_ADDR_BITS-1:0] addr);
    return {cmd, addr};
  endfunction

endpackage

// File: rtl/dbg_host_rx_unescape.sv
// Receive-side unescaping: classifies each popped byte against the escape
// state and assembles the payload LSB byte first.
module dbg_host_rx_unescape
  import uart_pkg::*;
#(
  parameter logic [7:0]  ESC       = ESC_DEFAULT,
  parameter int unsigned DMI_WIDTH = 41
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 valid,
  input  logic                 in_esc,
  input  logic [7:0]           rx_byte,
  output logic                 to_esc,
  output logic                 abort,
  output logic                 done,
  output logic [DMI_WIDTH-1:0] data
);

  localparam int unsigned NBYTES = (DMI_WIDTH + 7) / 8;
  localparam int unsigned BUF_W  = NBYTES * 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  logic [BUF_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             store;

  // After an escape only a second escape is legal; it stands for a literal.
  always_comb begin
    to_esc = valid && !in_esc && (rx_byte == ESC);
    abort  = valid && in_esc && (rx_byte != ESC);
    store  = valid && !to_esc && !abort;
    done   = store && (cnt == CNT_W'(NBYTES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (store) begin
      shreg <= {rx_byte, shreg[BUF_W-1:8]};
      cnt   <= cnt + 1'b1;
    end
  end

  assign data = shreg[DMI_WIDTH-1:0];

endmodule

// File: rtl/dbg_uart_host.sv
// Byte-stream debug host: frames register reads/writes over a UART byte
// interface. Define DBG_HOST_TIMEOUT_EN to enable the read-response timeout.
module dbg_uart_host
  import uart_pkg::*;
#(
  parameter logic [7:0]  ESC            = ESC_DEFAULT,
  parameter int unsigned DMI_WIDTH      = 41,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 REQ_VALID_I,
  output logic                 REQ_READY_O,
  input  logic                 REQ_WRITE_I,
  input  logic [IRLENGTH-1:0]  REQ_ADDRESS_I,
  input  logic [DMI_WIDTH-1:0] REQ_DATA_I,
  output logic                 RESP_VALID_O,
  input  logic                 RESP_READY_I,
  output logic [DMI_WIDTH-1:0] RESP_DATA_O,
  output logic                 RESP_ERROR_O,
  input  logic                 TX_READY_I,
  output logic                 TX_WRITE_O,
  output logic [7:0]           TX_DATA_O,
  input  logic                 RX_EMPTY_I,
  output logic                 RX_READ_O,
  input  logic [7:0]           RX_DATA_I
);

  localparam int unsigned NBYTES = (DMI_WIDTH + 7) / 8;
  localparam int unsigned TXW    = NBYTES * 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  host_state_e              state, state_d;
  logic                     write_q;
  logic [CMD_ADDR_BITS-1:0] addr_q;
  logic [TXW-1:0]           tx_buf;
  logic [CNT_W-1:0]         byte_cnt;
  logic                     err_q;

  logic                     accept, in_recv, rx_pop, rx_valid, last_byte;
  logic                     tx_write, tx_adv, set_err;
  logic [7:0]               tx_data;
  logic                     un_to_esc, un_abort, un_done;
  logic [DMI_WIDTH-1:0]     un_data;
  logic                     tmo_hit;
  logic                     unused_addr;

  assign accept    = REQ_VALID_I && (state == IDLE);
  assign in_recv   = (state == RECV) || (state == RECV_ESC);
  // The FIFO is drained in every state; bytes outside a read are dropped.
  assign rx_pop    = RST_NI && !RX_EMPTY_I;
  assign rx_valid  = rx_pop && in_recv;
  assign last_byte = (byte_cnt == CNT_W'(NBYTES - 1));
  assign unused_addr = ^REQ_ADDRESS_I[IRLENGTH-1:CMD_ADDR_BITS];

  dbg_host_rx_unescape #(
    .ESC       (ESC),
    .DMI_WIDTH (DMI_WIDTH)
  ) u_rx_unescape (
    .clk     (CLK_I),
    .rst_n   (RST_NI),
    .clear   (accept),
    .valid   (rx_valid),
    .in_esc  (state == RECV_ESC),
    .rx_byte (RX_DATA_I),
    .to_esc  (un_to_esc),
    .abort   (un_abort),
    .done    (un_done),
    .data    (un_data)
  );

`ifdef DBG_HOST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      tmo_cnt <= '0;
    end else if (!in_recv || rx_valid) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    tx_write = 1'b0;
    tx_data  = '0;
    tx_adv   = 1'b0;
    set_err  = 1'b0;
    case (state)
      IDLE: begin
        if (REQ_VALID_I) state_d = SEND_ESC;
      end
      SEND_ESC: begin
        tx_data  = ESC;
        tx_write = TX_READY_I;
        if (TX_READY_I) state_d = SEND_CMD;
      end
      SEND_CMD: begin
        tx_data  = cmd_byte(write_q ? CMD_WRITE : CMD_READ, addr_q);
        tx_write = TX_READY_I;
        if (TX_READY_I) state_d = write_q ? SEND_DATA : RECV;
      end
      SEND_DATA: begin
        tx_data  = tx_buf[7:0];
        tx_write = TX_READY_I;
        if (TX_READY_I) begin
          // An escape-valued payload byte stays put until its duplicate goes out.
          if (tx_buf[7:0] == ESC) begin
            state_d = SEND_DUP;
          end else begin
            tx_adv = 1'b1;
            if (last_byte) state_d = IDLE;
          end
        end
      end
      SEND_DUP: begin
        tx_data  = ESC;
        tx_write = TX_READY_I;
        if (TX_READY_I) begin
          tx_adv  = 1'b1;
          state_d = last_byte ? IDLE : SEND_DATA;
        end
      end
      RECV: begin
        if (un_to_esc) begin
          state_d = RECV_ESC;
        end else if (un_done) begin
          state_d = RESP;
        end else if (tmo_hit && !rx_valid) begin
          set_err = 1'b1;
          state_d = RESP;
        end
      end
      RECV_ESC: begin
        if (un_abort) begin
          set_err = 1'b1;
          state_d = RESP;
        end else if (un_done) begin
          state_d = RESP;
        end else if (rx_valid) begin
          state_d = RECV;
        end else if (tmo_hit) begin
          set_err = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (RESP_READY_I) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      tx_buf   <= '0;
      byte_cnt <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      write_q  <= REQ_WRITE_I;
      addr_q   <= REQ_ADDRESS_I[CMD_ADDR_BITS-1:0];
      tx_buf   <= TXW'(REQ_DATA_I);
      byte_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (tx_adv) begin
        tx_buf   <= tx_buf >> 8;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  assign REQ_READY_O  = (state == IDLE);
  assign RESP_VALID_O = (state == RESP);
  assign RESP_ERROR_O = (state == RESP) && err_q;
  assign RESP_DATA_O  = ((state == RESP) && !err_q) ? un_data : '0;
  assign TX_WRITE_O   = tx_write;
  assign TX_DATA_O    = tx_data;
  assign RX_READ_O    = rx_pop;

endmodule

// File: tb/tb_dbg_uart_host.sv
// Directed bench for dbg_uart_host: vector table of framed accesses plus
// hand sequences for idle/timeout waits and reset during a write.
module tb_dbg_uart_host;

  logic                          CLK_I;
  logic                          RST_NI;
  logic                          REQ_VALID_I;
  logic                          REQ_READY_O;
  logic                          REQ_WRITE_I;
  logic [uart_pkg::IRLENGTH-1:0] REQ_ADDRESS_I;
  logic [40:0]                   REQ_DATA_I;
  logic                          RESP_VALID_O;
  logic                          RESP_READY_I;
  logic [40:0]                   RESP_DATA_O;
  logic                          RESP_ERROR_O;
  logic                          TX_READY_I;
  logic                          TX_WRITE_O;
  logic [7:0]                    TX_DATA_O;
  logic                          RX_EMPTY_I;
  logic                          RX_READ_O;
  logic [7:0]                    RX_DATA_I;

  dbg_uart_host #(
    .ESC            (8'hB1),
    .DMI_WIDTH      (41),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLK_I         (CLK_I),
    .RST_NI        (RST_NI),
    .REQ_VALID_I   (REQ_VALID_I),
    .REQ_READY_O   (REQ_READY_O),
    .REQ_WRITE_I   (REQ_WRITE_I),
    .REQ_ADDRESS_I (REQ_ADDRESS_I),
    .REQ_DATA_I    (REQ_DATA_I),
    .RESP_VALID_O  (RESP_VALID_O),
    .RESP_READY_I  (RESP_READY_I),
    .RESP_DATA_O   (RESP_DATA_O),
    .RESP_ERROR_O  (RESP_ERROR_O),
    .TX_READY_I    (TX_READY_I),
    .TX_WRITE_O    (TX_WRITE_O),
    .TX_DATA_O     (TX_DATA_O),
    .RX_EMPTY_I    (RX_EMPTY_I),
    .RX_READ_O     (RX_READ_O),
    .RX_DATA_I     (RX_DATA_I)
  );

  typedef struct {
    logic        write;
    logic [6:0]  addr;
    logic [40:0] wdata;
    int          ntx;
    logic [95:0] tx;
    int          nrx;
    logic [95:0] rx;
    logic [40:0] rdata;
    logic        rerr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_mem [256];
  int         tx_cnt = 0;
  logic [7:0] rx_mem [64];
  int         rx_len = 0;
  int         rx_idx = 0;
  logic       mon_pop;

  vec_t vecs [8];

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  assign RX_EMPTY_I = (rx_idx >= rx_len);
  assign RX_DATA_I  = rx_mem[rx_idx % 64];

  // Byte-level monitor: captures transmitted bytes and advances the RX model.
  initial begin
    forever begin
      @(negedge CLK_I);
      mon_pop = RX_READ_O;
      if (TX_WRITE_O) begin
        tx_mem[tx_cnt % 256] = TX_DATA_O;
        tx_cnt++;
      end
      @(posedge CLK_I);
      #1;
      if (mon_pop) rx_idx++;
    end
  end

  task automatic tick;
    @(posedge CLK_I);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_len % 64] = b;
    rx_len++;
  endtask

  function automatic logic [7:0] nth(input logic [95:0] v, input int i);
    return v[95-8*i -: 8];
  endfunction

  function automatic vec_t mk(input logic w, input logic [6:0] a, input logic [40:0] d,
                              input int ntx, input logic [95:0] tx,
                              input int nrx, input logic [95:0] rx,
                              input logic [40:0] rd, input logic re);
    vec_t v;
    v.write = w;
    v.addr  = a;
    v.wdata = d;
    v.ntx   = ntx;
    v.tx    = tx << (8 * (12 - ntx));
    v.nrx   = nrx;
    v.rx    = rx << (8 * (12 - nrx));
    v.rdata = rd;
    v.rerr  = re;
    return v;
  endfunction

  task automatic issue(input logic w, input logic [6:0] a, input logic [40:0] d);
    REQ_WRITE_I   = w;
    REQ_ADDRESS_I = a;
    REQ_DATA_I    = d;
    REQ_VALID_I   = 1'b1;
    tick;
    REQ_VALID_I   = 1'b0;
    REQ_DATA_I    = '1;
    REQ_ADDRESS_I = '1;
  endtask

  task automatic wait_tx(input int base, input int n);
    int cyc;
    cyc = 0;
    while ((tx_cnt - base) < n && cyc < 200) begin
      tick;
      cyc++;
    end
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!RESP_VALID_O && cyc < 400) begin
      tick;
      cyc++;
    end
  endtask

  task automatic ack_resp(input string tag);
    RESP_READY_I = 1'b1;
    tick;
    RESP_READY_I = 1'b0;
    chk({tag, " idle after ack"}, {62'd0, RESP_VALID_O, REQ_READY_O}, 64'd1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int base, cyc;
    base = tx_cnt;
    chk($sformatf("v%0d ready before", k), REQ_READY_O, 1);
    issue(v.write, v.addr, v.wdata);
    if (v.write) begin
      wait_tx(base, v.ntx);
      chk($sformatf("v%0d idle after last byte", k), REQ_READY_O, 1);
    end else begin
      wait_tx(base, 2);
      for (int i = 0; i < v.nrx; i++) push_rx(nth(v.rx, i));
      wait_resp(cyc);
      chk($sformatf("v%0d resp valid", k), RESP_VALID_O, 1);
      chk($sformatf("v%0d resp data", k), RESP_DATA_O, v.rdata);
      chk($sformatf("v%0d resp error", k), RESP_ERROR_O, v.rerr);
      repeat (2) tick;
      chk($sformatf("v%0d resp held", k),
          {RESP_VALID_O, RESP_ERROR_O, RESP_DATA_O}, {1'b1, v.rerr, v.rdata});
      ack_resp($sformatf("v%0d", k));
      chk($sformatf("v%0d rx drained", k), rx_len - rx_idx, 0);
    end
    repeat (3) tick;
    chk($sformatf("v%0d tx count", k), tx_cnt - base, v.ntx);
    for (int i = 0; i < v.ntx; i++)
      chk($sformatf("v%0d tx byte %0d", k, i), tx_mem[(base + i) % 256], nth(v.tx, i));
  endtask

  initial begin
    int base, cyc;
    logic seen;
    RST_NI        = 1'b0;
    REQ_VALID_I   = 1'b0;
    REQ_WRITE_I   = 1'b0;
    REQ_ADDRESS_I = '0;
    REQ_DATA_I    = '0;
    RESP_READY_I  = 1'b0;
    TX_READY_I    = 1'b1;

    vecs[0] = mk(1'b1, 7'h10, 41'h0_1234_5678_9A, 8, 96'hB1_50_9A_78_56_34_12_00, 0, '0, '0, 1'b0);
    vecs[1] = mk(1'b1, 7'h10, 41'h0B1, 9, 96'hB1_50_B1_B1_00_00_00_00_00, 0, '0, '0, 1'b0);
    vecs[2] = mk(1'b1, 7'h7F, 41'h1FF_FFFF_FFFF, 8, 96'hB1_5F_FF_FF_FF_FF_FF_01, 0, '0, '0, 1'b0);
    vecs[3] = mk(1'b1, 7'h03, 41'h0B1_0000_00B1, 10, 96'hB1_43_B1_B1_00_00_00_B1_B1_00, 0, '0, '0, 1'b0);
    vecs[4] = mk(1'b0, 7'h11, '0, 2, 96'hB1_31, 6, 96'h01_02_03_04_05_FF, 41'h1_0504_0302_01, 1'b0);
    vecs[5] = mk(1'b0, 7'h11, '0, 2, 96'hB1_31, 7, 96'hB1_B1_00_00_00_00_00, 41'h0B1, 1'b0);
    vecs[6] = mk(1'b0, 7'h11, '0, 2, 96'hB1_31, 2, 96'hB1_22, '0, 1'b1);
    vecs[7] = mk(1'b0, 7'h00, '0, 2, 96'hB1_20, 7, 96'h10_B1_B1_20_30_40_80, 41'h0_4030_20B1_10, 1'b0);

    // A stray byte sits in the FIFO through reset and must be dropped in IDLE.
    push_rx(8'h77);
    repeat (3) tick;
    chk("reset rx_read", RX_READ_O, 0);
    chk("reset tx_write", TX_WRITE_O, 0);
    chk("reset resp", {RESP_VALID_O, RESP_ERROR_O, RESP_DATA_O}, '0);
    RST_NI = 1'b1;
    tick;
    chk("ready after reset", REQ_READY_O, 1);
    repeat (3) tick;
    chk("idle discard", rx_len - rx_idx, 0);
    chk("no tx after reset", tx_cnt, 0);

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    base = tx_cnt;
    issue(1'b0, 7'h05, '0);
    wait_tx(base, 2);
    chk("wait read tx count", tx_cnt - base, 2);
    chk("wait read cmd", tx_mem[(base + 1) % 256], 8'h25);
`ifdef DBG_HOST_TIMEOUT_EN
    wait_resp(cyc);
    chk("timeout cycles", cyc, 100);
    chk("timeout error", RESP_ERROR_O, 1);
    chk("timeout data", RESP_DATA_O, 0);
    ack_resp("timeout");
`else
    seen = 1'b0;
    repeat (150) begin
      tick;
      if (RESP_VALID_O) seen = 1'b1;
    end
    chk("no timeout", seen, 0);
    push_rx(8'hAA); push_rx(8'hBB); push_rx(8'hCC);
    push_rx(8'hDD); push_rx(8'hEE); push_rx(8'h00);
    wait_resp(cyc);
    chk("late read data", {RESP_ERROR_O, RESP_DATA_O}, {1'b0, 41'h0EE_DDCC_BBAA});
    ack_resp("late read");
`endif

    base = tx_cnt;
    issue(1'b1, 7'h10, 41'h0_1234_5678_9A);
    cyc = 0;
    while ((tx_cnt - base) < 5 && cyc < 200) begin
      TX_READY_I = ~TX_READY_I;
      tick;
      cyc++;
    end
    RST_NI     = 1'b0;
    TX_READY_I = 1'b1;
    #1;
    chk("tx_write in reset", TX_WRITE_O, 0);
    repeat (2) tick;
    RST_NI = 1'b1;
    tick;
    chk("ready after mid reset", REQ_READY_O, 1);
    chk("tx_write after mid reset", TX_WRITE_O, 0);
    repeat (5) tick;
    chk("mid reset tx count", tx_cnt - base, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("mid reset byte %0d", i), tx_mem[(base + i) % 256], nth(vecs[0].tx, i));

    run_vec(8, vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
